// File: rtl/mmio_port_responder.sv
// MMIO responder: three CPU-writable output ports, debounced switch inputs
// and a sticky input-changed status bit, all on the data-memory bus.
module mmio_port_responder #(
  parameter int SW_W            = 10,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic [31:0]     addr,
  input  logic [31:0]     datain,
  input  logic            we,
  input  logic            re,
  input  logic [SW_W-1:0] switch,
  output logic [31:0]     dataout,
  output logic [31:0]     out_port0,
  output logic [31:0]     out_port1,
  output logic [31:0]     out_port2,
  output logic            in_changed
);

  localparam int LO_W = SW_W / 2;
  localparam int HI_W = SW_W - LO_W;

  localparam logic [5:0] OFF_PORT0  = 6'h20;
  localparam logic [5:0] OFF_PORT1  = 6'h21;
  localparam logic [5:0] OFF_PORT2  = 6'h22;
  localparam logic [5:0] OFF_IN0    = 6'h30;
  localparam logic [5:0] OFF_IN1    = 6'h31;
  localparam logic [5:0] OFF_STATUS = 6'h32;

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [5:0]      off;
  logic            unused_addr;

  logic [31:0]     port0_q, port0_d;
  logic [31:0]     port1_q, port1_d;
  logic [31:0]     port2_q, port2_d;
  logic [SW_W-1:0] sync1_q, sync2_q;
  logic [SW_W-1:0] sw_db_q, sw_db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            chg_q, chg_d;
  logic            accept;
  logic [31:0]     in0, in1;

  assign off         = addr[7:2];
  assign unused_addr = ^{addr[31:8], addr[1:0]};

  assign in0 = {{(32-HI_W){1'b0}}, sw_db_q[SW_W-1:LO_W]};
  assign in1 = {{(32-LO_W){1'b0}}, sw_db_q[LO_W-1:0]};

  // Port writes
  always_comb begin
    port0_d = port0_q;
    port1_d = port1_q;
    port2_d = port2_q;
    if (we) begin
      unique case (off)
        OFF_PORT0: port0_d = datain;
        OFF_PORT1: port1_d = datain;
        OFF_PORT2: port2_d = datain;
        default: ;
      endcase
    end
  end

  // One shared counter; any return to sw_db restarts it
  always_comb begin
    sw_db_d = sw_db_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    if (sync2_q == sw_db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      sw_db_d = sync2_q;
      cnt_d   = '0;
      accept  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Set wins over a same-cycle clearing read
  always_comb begin
    chg_d = chg_q;
    if (re && off == OFF_STATUS) chg_d = 1'b0;
    if (accept) chg_d = 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      port0_q <= '0;
      port1_q <= '0;
      port2_q <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      sw_db_q <= '0;
      cnt_q   <= '0;
      chg_q   <= 1'b0;
    end else begin
      port0_q <= port0_d;
      port1_q <= port1_d;
      port2_q <= port2_d;
      sync1_q <= switch;
      sync2_q <= sync1_q;
      sw_db_q <= sw_db_d;
      cnt_q   <= cnt_d;
      chg_q   <= chg_d;
    end
  end

  always_comb begin
    dataout = '0;
    unique case (off)
      OFF_PORT0:  dataout = port0_q;
      OFF_PORT1:  dataout = port1_q;
      OFF_PORT2:  dataout = port2_q;
      OFF_IN0:    dataout = in0;
      OFF_IN1:    dataout = in1;
      OFF_STATUS: dataout = {31'b0, chg_q};
      default:    dataout = '0;
    endcase
  end

  assign out_port0  = port0_q;
  assign out_port1  = port1_q;
  assign out_port2  = port2_q;
  assign in_changed = chg_q;

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed bench for mmio_port_responder with a short debounce window
// so switch acceptance lands 6 clocks after a change.
module tb_mmio_port_responder;

  logic        clock = 1'b0;
  logic        resetn;
  logic [31:0] addr;
  logic [31:0] datain;
  logic        we;
  logic        re;
  logic [9:0]  switch;
  logic [31:0] dataout;
  logic [31:0] out_port0;
  logic [31:0] out_port1;
  logic [31:0] out_port2;
  logic        in_changed;

  int checks = 0;
  int errors = 0;

  mmio_port_responder #(
    .SW_W(10),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(4)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .addr(addr),
    .datain(datain),
    .we(we),
    .re(re),
    .switch(switch),
    .dataout(dataout),
    .out_port0(out_port0),
    .out_port1(out_port1),
    .out_port2(out_port2),
    .in_changed(in_changed)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic rd(input string tag,
                    input logic [31:0] a,
                    input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, dataout, exp);
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d);
    addr   = a;
    datain = d;
    we     = 1'b1;
    tick();
    we     = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    addr   = '0;
    datain = '0;
    we     = 1'b0;
    re     = 1'b0;
    switch = '0;
    tick(3);
    resetn = 1'b1;
    tick();

    chk("rst_p0", out_port0, 0);
    chk("rst_p1", out_port1, 0);
    chk("rst_p2", out_port2, 0);
    chk("rst_chg", {31'b0, in_changed}, 0);
    rd("rst_in0", 32'hC0, 0);
    rd("rst_in1", 32'hC4, 0);
    rd("rst_st", 32'hC8, 0);

    addr   = 32'h80;
    datain = 32'd42;
    we     = 1'b1;
    #1;
    chk("raw_old", dataout, 0);
    tick();
    we = 1'b0;
    chk("wr_p0", out_port0, 42);
    wr(32'h84, 32'd7);
    chk("wr_p1", out_port1, 7);
    wr(32'h88, 32'd99);
    chk("wr_p2", out_port2, 99);
    rd("rb_p0", 32'h80, 42);
    rd("rb_p1", 32'h85, 7);
    rd("rb_p2", 32'hFFFF_FF88, 99);
    wr(32'hC0, 32'hFFFF);
    rd("ro_in0", 32'hC0, 0);
    wr(32'h90, 32'h1234);
    rd("unm_90", 32'h90, 0);
    chk("unm_p0", out_port0, 42);
    chk("unm_p1", out_port1, 7);
    chk("unm_p2", out_port2, 99);

    switch = 10'b10101_00011;
    tick(5);
    rd("cln5_in0", 32'hC0, 0);
    rd("cln5_in1", 32'hC4, 0);
    chk("cln5_chg", {31'b0, in_changed}, 0);
    tick();
    rd("cln6_in0", 32'hC0, 21);
    rd("cln6_in1", 32'hC4, 3);
    chk("cln6_chg", {31'b0, in_changed}, 1);

    addr = 32'hC8;
    re   = 1'b1;
    #1;
    chk("clr_rd", dataout, 1);
    tick();
    re = 1'b0;
    chk("clr_chg", {31'b0, in_changed}, 0);

    switch = 10'b10101_00010;
    tick(10);
    rd("base_in1", 32'hC4, 2);
    addr = 32'hC8;
    re   = 1'b1;
    tick();
    re = 1'b0;
    chk("base_clr", {31'b0, in_changed}, 0);

    switch[0] = 1'b1;
    tick(2);
    switch[0] = 1'b0;
    tick(2);
    switch[0] = 1'b1;
    tick(5);
    rd("bnc5_in1", 32'hC4, 2);
    chk("bnc5_chg", {31'b0, in_changed}, 0);
    tick();
    rd("bnc6_in1", 32'hC4, 3);
    chk("bnc6_chg", {31'b0, in_changed}, 1);

    addr = 32'hC8;
    re   = 1'b1;
    #1;
    chk("clr2_rd", dataout, 1);
    tick();
    re = 1'b0;
    chk("clr2_chg", {31'b0, in_changed}, 0);

    switch = 10'b00000_00011;
    tick(5);
    addr = 32'hC8;
    re   = 1'b1;
    #1;
    chk("col_rd", dataout, 0);
    tick();
    re = 1'b0;
    chk("col_chg", {31'b0, in_changed}, 1);
    rd("col_in0", 32'hC0, 0);

    switch = 10'b11111_00000;
    tick(3);
    addr = 32'h80;
    #2;
    resetn = 1'b0;
    #1;
    chk("ar_p0", out_port0, 0);
    chk("ar_p1", out_port1, 0);
    chk("ar_p2", out_port2, 0);
    chk("ar_chg", {31'b0, in_changed}, 0);
    chk("ar_dout", dataout, 0);
    rd("ar_in1", 32'hC4, 0);
    resetn = 1'b1;
    tick(5);
    rd("ar5_in0", 32'hC0, 0);
    chk("ar5_chg", {31'b0, in_changed}, 0);
    tick();
    rd("ar6_in0", 32'hC0, 31);
    rd("ar6_in1", 32'hC4, 0);
    chk("ar6_chg", {31'b0, in_changed}, 1);
    chk("ar6_p0", out_port0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
